// File: rtl/serial_byte_receiver.sv
`default_nettype none
// ============================================================================
// Module      : serial_byte_receiver
// Description : Serial-to-parallel receiver. Strobed serial bits are gathered
//               into a shift stage (LSB-first or MSB-first, latched per word),
//               each completed word moves to a holding register and is offered
//               with a valid/ack handshake. A completion that arrives while the
//               previous word is still pending and not acked is dropped, and it
//               sets a sticky overrun flag.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   c    in   1  clock, rising edge
//   rst  in   1  asynchronous reset, active-high
//   i    in   1  serial data bit
//   en   in   1  bit strobe (i sampled when en=1)
//   dir  in   1  bit order: 0 = LSB-first, 1 = MSB-first
//   clr  in   1  synchronous clear of partial word and overrun flag
//   ack  in   1  consumer accepts q (only while v=1)
//   q    out  W  received word
//   v    out  1  q holds an unconsumed word
//   ovr  out  1  sticky overrun flag
//   busy out  1  partial word in progress
// ============================================================================
module serial_byte_receiver #(
  parameter int W = 8
) (
  input  logic         c,
  input  logic         rst,
  input  logic         i,
  input  logic         en,
  input  logic         dir,
  input  logic         clr,
  input  logic         ack,
  output logic [W-1:0] q,
  output logic         v,
  output logic         ovr,
  output logic         busy
);

  localparam int c_CW = (W > 2) ? $clog2(W) : 1;
  localparam logic [c_CW-1:0] c_LAST = c_CW'(W - 1);

  logic [W-1:0]    r_sh;
  logic [c_CW-1:0] r_cnt;
  logic            r_dl;
  logic [W-1:0]    r_q;
  logic            r_v;
  logic            r_ovr;

  logic            w_idle;
  logic            w_dir;
  logic [W-1:0]    w_sh_next;
  logic            w_complete;

  // IDLE is cnt==0; any other count means a word is being collected.
  assign w_idle     = (r_cnt == '0);
  // The first bit of a word uses the live dir input; later bits use the latch.
  assign w_dir      = w_idle ? dir : r_dl;
  assign w_sh_next  = w_dir ? {r_sh[W-2:0], i} : {i, r_sh[W-1:1]};
  // clr wins over en, so a clear cycle can never complete a word.
  assign w_complete = en && !clr && (r_cnt == c_LAST);

  always_ff @(posedge c or posedge rst) begin
    if (rst) begin
      r_sh  <= '0;
      r_cnt <= '0;
      r_dl  <= 1'b0;
      r_q   <= '0;
      r_v   <= 1'b0;
      r_ovr <= 1'b0;
    end else begin
      // Shift stage and bit counter
      if (clr) begin
        r_sh  <= '0;
        r_cnt <= '0;
      end else if (en) begin
        r_sh  <= w_sh_next;
        r_cnt <= (r_cnt == c_LAST) ? '0 : r_cnt + 1'b1;
        if (w_idle) begin
          r_dl <= dir;
        end
      end

      // Holding register and handshake; ack is honoured even during clr.
      if (w_complete) begin
        if (!r_v || ack) begin
          r_q <= w_sh_next;
          r_v <= 1'b1;
        end
      end else if (r_v && ack) begin
        r_v <= 1'b0;
      end

      // Sticky overrun: only clr (or reset) clears it.
      if (clr) begin
        r_ovr <= 1'b0;
      end else if (w_complete && r_v && !ack) begin
        r_ovr <= 1'b1;
      end
    end
  end

  assign q    = r_q;
  assign v    = r_v;
  assign ovr  = r_ovr;
  assign busy = !w_idle;

endmodule
`default_nettype wire

// File: tb/tb_serial_byte_receiver.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_byte_receiver
// Description : Directed self-checking bench for serial_byte_receiver (W=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_byte_receiver;

  logic       c;
  logic       rst;
  logic       i;
  logic       en;
  logic       dir;
  logic       clr;
  logic       ack;
  logic [7:0] q;
  logic       v;
  logic       ovr;
  logic       busy;

  int checks;
  int errors;

  serial_byte_receiver #(.W(8)) dut (
    .c    (c),
    .rst  (rst),
    .i    (i),
    .en   (en),
    .dir  (dir),
    .clr  (clr),
    .ack  (ack),
    .q    (q),
    .v    (v),
    .ovr  (ovr),
    .busy (busy)
  );

  initial c = 1'b0;
  always #5 c = ~c;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock edge; inputs are sampled by the DUT, outputs checked 1 time unit later.
  task automatic step();
    @(posedge c);
    #1;
  endtask

  // Send the first n bits of word w in order d. From bit index flip_at on,
  // the dir input is inverted (should be ignored mid-word). ack_last raises
  // ack together with the last strobe. max_gap > 0 inserts random idle
  // cycles and checks that v stays low until the 8th strobe.
  task automatic send(input logic [7:0] w, input logic d, input int n,
                      input int flip_at, input logic ack_last, input int max_gap);
    int g;
    for (int k = 0; k < n; k++) begin
      g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      for (int j = 0; j < g; j++) step();
      i   = d ? w[7-k] : w[k];
      dir = (flip_at >= 0 && k >= flip_at) ? ~d : d;
      en  = 1'b1;
      ack = ack_last && (k == n - 1);
      step();
      en  = 1'b0;
      ack = 1'b0;
      if (max_gap > 0 && k < 7) chk("v_early", 32'(v), 32'd0);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1; i = 1'b0; en = 1'b0; dir = 1'b0; clr = 1'b0; ack = 1'b0;
    step();
    step();
    chk("rst_q", 32'(q), 32'h00);
    chk("rst_v", 32'(v), 32'd0);
    chk("rst_ovr", 32'(ovr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    step();
    step();
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_v", 32'(v), 32'd0);

    // 1: LSB-first 1,0,1,1,0,0,1,0 -> 8'h4D
    send(8'h4D, 1'b0, 7, -1, 1'b0, 0);
    chk("t1_busy_mid", 32'(busy), 32'd1);
    chk("t1_v_mid", 32'(v), 32'd0);
    send(8'h4D >> 7, 1'b0, 1, -1, 1'b0, 0);  // bit 7 of 4D is 0
    chk("t1_q", 32'(q), 32'h4D);
    chk("t1_v", 32'(v), 32'd1);
    chk("t1_busy", 32'(busy), 32'd0);
    ack = 1'b1; step(); ack = 1'b0;
    chk("t1_v_ack", 32'(v), 32'd0);
    chk("t1_q_ack", 32'(q), 32'h4D);

    // 2: MSB-first 1,0,1,1,0,0,1,0 -> 8'hB2; repeat with dir toggled after bit 3
    send(8'hB2, 1'b1, 8, -1, 1'b0, 0);
    chk("t2_q", 32'(q), 32'hB2);
    chk("t2_v", 32'(v), 32'd1);
    ack = 1'b1; step(); ack = 1'b0;
    send(8'hB2, 1'b1, 8, 3, 1'b0, 0);
    chk("t2_q_flip", 32'(q), 32'hB2);
    chk("t2_v_flip", 32'(v), 32'd1);
    ack = 1'b1; step(); ack = 1'b0;
    chk("t2_v_ack", 32'(v), 32'd0);

    // 3: overrun
    send(8'hA5, 1'b0, 8, -1, 1'b0, 0);
    chk("t3_q1", 32'(q), 32'hA5);
    chk("t3_ovr1", 32'(ovr), 32'd0);
    send(8'h3C, 1'b0, 8, -1, 1'b0, 0);
    chk("t3_q2", 32'(q), 32'hA5);
    chk("t3_v2", 32'(v), 32'd1);
    chk("t3_ovr2", 32'(ovr), 32'd1);
    ack = 1'b1; step(); ack = 1'b0;
    chk("t3_v_ack", 32'(v), 32'd0);
    chk("t3_ovr_ack", 32'(ovr), 32'd1);
    clr = 1'b1; step(); clr = 1'b0;
    chk("t3_ovr_clr", 32'(ovr), 32'd0);
    chk("t3_q_clr", 32'(q), 32'hA5);

    // 4: completion coincident with ack of the pending word
    send(8'hA5, 1'b0, 8, -1, 1'b0, 0);
    chk("t4_q1", 32'(q), 32'hA5);
    send(8'h3C, 1'b0, 8, -1, 1'b1, 0);
    chk("t4_q2", 32'(q), 32'h3C);
    chk("t4_v2", 32'(v), 32'd1);
    chk("t4_ovr", 32'(ovr), 32'd0);
    ack = 1'b1; step(); ack = 1'b0;
    chk("t4_v_ack", 32'(v), 32'd0);

    // 5: abort with clr+en after 5 bits, then a clean word
    send(8'hFF, 1'b0, 5, -1, 1'b0, 0);
    chk("t5_busy_mid", 32'(busy), 32'd1);
    clr = 1'b1; en = 1'b1; i = 1'b1; step(); clr = 1'b0; en = 1'b0;
    chk("t5_busy_clr", 32'(busy), 32'd0);
    chk("t5_v_clr", 32'(v), 32'd0);
    send(8'h96, 1'b0, 8, -1, 1'b0, 0);
    chk("t5_q", 32'(q), 32'h96);
    chk("t5_v", 32'(v), 32'd1);

    // 6: asynchronous reset mid-word (q=96, v=1 pending beforehand)
    send(8'hFF, 1'b1, 4, -1, 1'b0, 0);
    chk("t6_busy_mid", 32'(busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_busy_rst", 32'(busy), 32'd0);
    chk("t6_v_rst", 32'(v), 32'd0);
    chk("t6_q_rst", 32'(q), 32'h00);
    chk("t6_ovr_rst", 32'(ovr), 32'd0);
    step();
    rst = 1'b0;
    step();
    send(8'h5A, 1'b1, 8, -1, 1'b0, 3);
    chk("t6_q", 32'(q), 32'h5A);
    chk("t6_v", 32'(v), 32'd1);
    chk("t6_busy", 32'(busy), 32'd0);
    step();
    step();
    chk("t6_v_level", 32'(v), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
